// File: rtl/div_pkg.sv
// Shared definitions for the iterative radix-2 divider.
// Contents:
//   DIV_WIDTH_DEFAULT - default operand width.
//   DIV_ZERO_QUO      - quotient returned for a zero divisor (all ones).
//   div_state_e       - control states: idle, iterate, sign fix-up, result held.
package div_pkg;

  localparam int unsigned DIV_WIDTH_DEFAULT = 32;

  localparam logic [DIV_WIDTH_DEFAULT-1:0] DIV_ZERO_QUO = '1;

  typedef enum logic [1:0] {
    StIdle,
    StIter,
    StFix,
    StDone
  } div_state_e;

endpackage

// File: rtl/radix2_div_step.sv
// One combinational restoring-division step.
// Ports:
//   rem      - partial remainder (WIDTH+1 bits, unsigned).
//   quo      - quotient/dividend shift register (WIDTH bits).
//   divisor  - divisor magnitude (WIDTH+1 bits, unsigned).
//   rem_next - remainder after shift and trial subtract.
//   quo_next - quo shifted left with the new quotient bit in the LSB.
module radix2_div_step
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic [WIDTH:0]   rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH:0]   divisor,
  output logic [WIDTH:0]   rem_next,
  output logic [WIDTH-1:0] quo_next
);

  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] trial;
  logic             fits;

  always_comb begin
    // One extra bit so the subtraction borrow lands in the MSB.
    shifted  = {rem, quo[WIDTH-1]};
    trial    = shifted - {1'b0, divisor};
    fits     = ~trial[WIDTH+1];
    rem_next = fits ? trial[WIDTH:0] : shifted[WIDTH:0];
    quo_next = {quo[WIDTH-2:0], fits};
  end

endmodule

// File: rtl/radix2_divider.sv
// Iterative signed/unsigned restoring radix-2 divider, one quotient bit per cycle.
// Results truncate toward zero; the remainder takes the sign of the dividend.
// Optional feature macro: DIV_EARLY_OUT_EN - when defined, operands with |X| < |Y|
// (Y nonzero) skip the iteration and complete one edge after accept.
// Ports:
//   clk, rst_n          - clock, synchronous active-low reset.
//   in_valid, in_ready  - operand handshake; in_ready high only when idle.
//   signed_op           - 1 = two's-complement operands; sampled on accept.
//   X, Y                - dividend, divisor.
//   out_valid, out_ready- result handshake; result held until taken.
//   Q, Rem              - quotient, remainder.
//   div_zero            - divisor was zero (qualified by out_valid).
module radix2_divider
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Rem,
  output logic             div_zero
);

  localparam int unsigned     CntW     = $clog2(WIDTH);
  localparam logic [CntW-1:0] CntLast  = CntW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] ZeroQuo = {WIDTH{DIV_ZERO_QUO[0]}};

  div_state_e       state_q, state_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH:0]   dvsr_q, dvsr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             quo_neg_q, quo_neg_d;
  logic             rem_neg_q, rem_neg_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] q_out_q, q_out_d;
  logic [WIDTH-1:0] rem_out_q, rem_out_d;
  logic             div_zero_q, div_zero_d;

  logic [WIDTH-1:0] mag_x;
  logic [WIDTH-1:0] mag_y;
  logic             y_zero;
  logic [WIDTH:0]   step_rem;
  logic [WIDTH-1:0] step_quo;

  // Negating the most-negative value yields 2^(WIDTH-1), which is exact as unsigned.
  always_comb begin
    mag_x  = (signed_op && X[WIDTH-1]) ? -X : X;
    mag_y  = (signed_op && Y[WIDTH-1]) ? -Y : Y;
    y_zero = (Y == '0);
  end

  radix2_div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .rem      (rem_q),
    .quo      (quo_q),
    .divisor  (dvsr_q),
    .rem_next (step_rem),
    .quo_next (step_quo)
  );

  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    dvsr_d     = dvsr_q;
    cnt_d      = cnt_q;
    quo_neg_d  = quo_neg_q;
    rem_neg_d  = rem_neg_q;
    dz_d       = dz_q;
    q_out_d    = q_out_q;
    rem_out_d  = rem_out_q;
    div_zero_d = div_zero_q;

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          quo_neg_d = signed_op & (X[WIDTH-1] ^ Y[WIDTH-1]);
          rem_neg_d = signed_op & X[WIDTH-1];
          dvsr_d    = {1'b0, mag_y};
          cnt_d     = CntLast;
          dz_d      = y_zero;
          if (y_zero) begin
            // Park the raw dividend in rem so FIX returns it unmodified.
            rem_d     = {1'b0, X};
            quo_d     = '0;
            rem_neg_d = 1'b0;
            state_d   = StFix;
          end
`ifdef DIV_EARLY_OUT_EN
          else if (mag_x < mag_y) begin
            rem_d   = {1'b0, mag_x};
            quo_d   = '0;
            state_d = StFix;
          end
`endif
          else begin
            rem_d   = '0;
            quo_d   = mag_x;
            state_d = StIter;
          end
        end
      end

      StIter: begin
        rem_d = step_rem;
        quo_d = step_quo;
        if (cnt_q == '0) begin
          state_d = StFix;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      StFix: begin
        if (dz_q) begin
          q_out_d = ZeroQuo;
        end else begin
          q_out_d = quo_neg_q ? -quo_q : quo_q;
        end
        rem_out_d  = rem_neg_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
        div_zero_d = dz_q;
        state_d    = StDone;
      end

      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      rem_q      <= '0;
      quo_q      <= '0;
      dvsr_q     <= '0;
      cnt_q      <= '0;
      quo_neg_q  <= 1'b0;
      rem_neg_q  <= 1'b0;
      dz_q       <= 1'b0;
      q_out_q    <= '0;
      rem_out_q  <= '0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      dvsr_q     <= dvsr_d;
      cnt_q      <= cnt_d;
      quo_neg_q  <= quo_neg_d;
      rem_neg_q  <= rem_neg_d;
      dz_q       <= dz_d;
      q_out_q    <= q_out_d;
      rem_out_q  <= rem_out_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign Q         = q_out_q;
  assign Rem       = rem_out_q;
  assign div_zero  = div_zero_q;

endmodule

// File: doc/radix2_divider.md
# radix2_divider

Iterative 32-bit signed/unsigned integer divider, the inverse companion to the combinational Booth/Wallace multiplier in the arithmetic datapath. It accepts a dividend/divisor pair over a valid/ready handshake. It computes quotient and remainder by restoring radix-2 division, one quotient bit per cycle, and holds the result until the consumer takes it. Results truncate toward zero, and the remainder takes the sign of the dividend.

## Interface
- WIDTH, 32, operand width in bits; quotient and remainder are also WIDTH bits.
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous, active-low reset.
- in_valid  input  1  operands present.
- in_ready  output  1  divider idle and able to accept operands.
- signed_op  input  1  1 = two's-complement operands, 0 = unsigned; sampled on accept.
- X  input  WIDTH  dividend.
- Y  input  WIDTH  divisor.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer takes the result.
- Q  output  WIDTH  quotient.
- Rem  output  WIDTH  remainder.
- div_zero  output  1  Y was zero; qualified by out_valid.

## Operation
- States: IDLE, ITER, FIX, DONE. `in_ready = (state == IDLE)`. `out_valid = (state == DONE)`.
- Accept (in_valid && in_ready):
  - Latch the magnitudes |X| and |Y|. Absolute values are taken only when signed_op=1.
  - Latch neg_q = signed_op & (X[msb] ^ Y[msb]) and neg_r = signed_op & X[msb].
  - Clear the partial remainder (WIDTH+1 bits).
  - Load the iteration counter with WIDTH-1.
  - Go to ITER. If Y == 0, go to FIX instead.
- ITER, one step per cycle:
  - Shift {rem, quo} left by 1.
  - Compute trial = rem − |Y|.
  - If trial ≥ 0, rem ← trial and the new quo LSB = 1; otherwise the LSB = 0.
  - Decrement the counter. Leave for FIX after the step taken at counter 0.
- FIX:
  - Q ← neg_q ? −quo : quo.
  - Rem ← neg_r ? −rem : rem.
  - Go to DONE.
- DONE: hold Q, Rem and div_zero stable. On out_ready, go to IDLE.
- Divide by zero: Q = all ones, Rem = X unmodified, div_zero = 1. This applies regardless of signed_op.
- Signed overflow (most negative / −1): the magnitude path yields Q = 0x8000_0000 and Rem = 0. No special case.
- All magnitude arithmetic is unsigned on WIDTH+1 bits. The most-negative dividend's magnitude 2^(WIDTH−1) is represented exactly.
- Reset (rst_n low at a clock edge): state ← IDLE, Q/Rem/div_zero ← 0, out_valid ← 0, in_ready ← 1. This applies in any state, including mid-ITER; in-flight work is discarded.

## Timing
- Normal operation: out_valid rises after WIDTH+1 clock edges following the accept edge (33 for WIDTH=32).
  - Edges 1..WIDTH perform ITER.
  - Edge WIDTH+1 performs FIX.
- Divide by zero: out_valid rises 1 edge after accept.
- Result consumed at edge E (out_valid && out_ready): in_ready is high in the cycle after E. There is no same-cycle result-drain and accept.
- With out_ready held low: out_valid stays high, outputs stay constant, in_ready stays low, and in_valid is ignored.
- in_valid raised mid-operation is not accepted. The producer must hold X, Y and signed_op until in_ready.
- No combinational path from in_valid/out_ready to any output except through state.

## Configuration
- DIV_EARLY_OUT_EN defined:
  - On accept, if |X| < |Y| and Y ≠ 0, skip ITER and go straight to FIX with quo = 0 and rem = |X|.
  - The result is Q = 0, Rem = X, out_valid 1 edge after accept.
- DIV_EARLY_OUT_EN undefined: every nonzero divisor takes the full WIDTH+1 edge latency.
- Numerical results are identical either way.

## Structure
- Package div_pkg holds:
  - the state enum (IDLE, ITER, FIX, DONE);
  - DIV_WIDTH_DEFAULT = 32;
  - the divide-by-zero quotient constant (all ones).
- Sub-module radix2_div_step is combinational: one shift/trial-subtract/select step.
  - Inputs: rem, quo, divisor.
  - Outputs: rem_next, quo_next.
  - Instantiated once inside the FSM datapath.

## Test plan
- Unsigned: signed_op=0, X=100, Y=7 → Q=14, Rem=2, div_zero=0, out_valid exactly 33 edges after accept.
- Signed mixed sign: signed_op=1, X=−100 (0xFFFFFF9C), Y=7 → Q=0xFFFFFFF2 (−14), Rem=0xFFFFFFFE (−2). Also X=100, Y=−7 → Q=−14, Rem=2.
- Divide by zero: X=0x12345678, Y=0 → Q=0xFFFFFFFF, Rem=0x12345678, div_zero=1, out_valid 1 edge after accept.
- Overflow: signed_op=1, X=0x80000000, Y=0xFFFFFFFF → Q=0x80000000, Rem=0. Unsigned 0xFFFFFFFF/1 → Q=0xFFFFFFFF, Rem=0.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid while in_valid=1 → outputs stable, in_ready=0, no second accept. Release → in_ready=1 the following cycle.
- Reset mid-ITER: drop rst_n for one edge at iteration 10 → next cycle in_ready=1, out_valid=0, Q=Rem=0. A fresh 100/7 then completes normally.
